// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared instruction-set constants for the pipeline stall controller.
// Opcode encodings and the NOP word used for bubbles and reset.
package pipeline_stall_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OP_HALT = 6'h3F;

    localparam logic [WIDTH-1:0] NOP_WORD = {OP_NOP, {(WIDTH-OPC_W){1'b0}}};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_stall_watchdog.sv
// Stall statistics: saturating total stall-cycle counter, consecutive-stall
// counter and a sticky timeout once the consecutive run reaches MAX_STALL.
module stall_watchdog #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             clear,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0]    CONSEC_MAX = CW'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [CW-1:0] consec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            consec        <= '0;
            stall_timeout <= 1'b0;
        end else if (count_en) begin
            if (stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (consec != CONSEC_MAX)
                consec <= consec + 1'b1;
            // trips on the edge that brings the run up to MAX_STALL
            if (consec >= CONSEC_MAX - 1'b1)
                stall_timeout <= 1'b1;
        end else if (clear) begin
            consec <= '0;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// IR pipeline register chain (ID..WB) with stall bubbles, branch flush,
// HALT retirement and the PC-advance enable.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | pipeline advancing; stalls/flushes applied each edge
// ST_HALT | HALT retired at WB; IRs, PC and statistics frozen until reset
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IR_IF,
    input  logic             IsStall_IF,
    input  logic             IsStall_ID,
    input  logic             flush,
    output logic [WIDTH-1:0] IR_ID,
    output logic [WIDTH-1:0] IR_EXE,
    output logic [WIDTH-1:0] IR_MEM,
    output logic [WIDTH-1:0] IR_WB,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_timeout
);

    localparam logic [WIDTH-1:0] NOP_W = {OP_NOP, {(WIDTH-OPC_W){1'b0}}};

    state_t state;
    logic   stall;
    logic   count_en;
    logic   clear;

    assign stall    = IsStall_IF | IsStall_ID;
    assign pc_en    = ~halted & (flush | ~stall);
    assign count_en = ~halted & stall & ~flush;
    assign clear    = ~halted & (flush | ~stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            halted <= 1'b0;
            IR_ID  <= NOP_W;
            IR_EXE <= NOP_W;
            IR_MEM <= NOP_W;
            IR_WB  <= NOP_W;
        end else begin
            case (state)
                ST_RUN: begin
                    IR_WB  <= IR_MEM;
                    IR_MEM <= IR_EXE;
                    if (flush) begin
                        IR_ID  <= NOP_W;
                        IR_EXE <= NOP_W;
                    end else if (stall) begin
                        IR_EXE <= NOP_W;
                    end else begin
                        IR_ID  <= IR_IF;
                        IR_EXE <= IR_ID;
                    end
                    // HALT reaches WB on this edge; anything younger is discarded
                    if (IR_MEM[WIDTH-1 -: OPC_W] == OP_HALT) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state  <= ST_HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    stall_watchdog #(
        .CNT_W     (CNT_W),
        .MAX_STALL (MAX_STALL)
    ) u_stall_watchdog (
        .clk           (clk),
        .rst_n         (rst_n),
        .count_en      (count_en),
        .clear         (clear),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a reference pipeline model
// queues expected post-edge state, compared against the DUT after each edge.
module tb_pipeline_stall_ctrl;

    localparam int TB_CNT_W  = 4;
    localparam int MAX_STALL = 4;
    localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;
    localparam logic [31:0] NOP_W  = 32'h0000_0000;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    typedef struct packed {
        logic [31:0]         id;
        logic [31:0]         exe;
        logic [31:0]         mem;
        logic [31:0]         wb;
        logic                pc;
        logic                halt;
        logic                tmo;
        logic [TB_CNT_W-1:0] cnt;
    } snap_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [31:0]         IR_IF = '0;
    logic                IsStall_IF = 1'b0;
    logic                IsStall_ID = 1'b0;
    logic                flush = 1'b0;
    logic [31:0]         IR_ID, IR_EXE, IR_MEM, IR_WB;
    logic                pc_en, halted, stall_timeout;
    logic [TB_CNT_W-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    snap_t exp_q[$];
    snap_t act_q[$];

    logic [31:0] m_id, m_exe, m_mem, m_wb;
    logic        m_halt, m_tmo;
    int          m_cnt, m_consec;

    pipeline_stall_ctrl #(
        .WIDTH     (32),
        .CNT_W     (TB_CNT_W),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .IR_IF         (IR_IF),
        .IsStall_IF    (IsStall_IF),
        .IsStall_ID    (IsStall_ID),
        .flush         (flush),
        .IR_ID         (IR_ID),
        .IR_EXE        (IR_EXE),
        .IR_MEM        (IR_MEM),
        .IR_WB         (IR_WB),
        .pc_en         (pc_en),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_id = NOP_W; m_exe = NOP_W; m_mem = NOP_W; m_wb = NOP_W;
        m_halt = 1'b0; m_tmo = 1'b0; m_cnt = 0; m_consec = 0;
    endtask

    // Called mid-cycle; leaves time at posedge+1 with inputs idle.
    task automatic do_reset();
        IR_IF = NOP_W; IsStall_IF = 1'b0; IsStall_ID = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Drive one cycle of stimulus, queue the model's expectation, clock it.
    task automatic drive(input logic [31:0] ir, input logic sif, input logic sid, input logic fl);
        snap_t e, a;
        logic  st, nh;
        IR_IF = ir; IsStall_IF = sif; IsStall_ID = sid; flush = fl;
        #1;
        st = sif | sid;
        e.pc = ~m_halt & (fl | ~st);
        a.pc = pc_en;
        if (!m_halt) begin
            nh = (m_mem[31:26] == 6'h3F);
            if (st && !fl) begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (m_consec < MAX_STALL) m_consec = m_consec + 1;
                if (m_consec == MAX_STALL) m_tmo = 1'b1;
            end else begin
                m_consec = 0;
            end
            m_wb  = m_mem;
            m_mem = m_exe;
            m_exe = (fl || st) ? NOP_W : m_id;
            m_id  = fl ? NOP_W : (st ? m_id : ir);
            m_halt = nh;
        end
        e.id = m_id; e.exe = m_exe; e.mem = m_mem; e.wb = m_wb;
        e.halt = m_halt; e.tmo = m_tmo; e.cnt = TB_CNT_W'(m_cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a.id = IR_ID; a.exe = IR_EXE; a.mem = IR_MEM; a.wb = IR_WB;
        a.halt = halted; a.tmo = stall_timeout; a.cnt = stall_cnt;
        act_q.push_back(a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({IR_ID, IR_EXE, IR_MEM, IR_WB} !== {4{NOP_W}} || halted !== 1'b0 || stall_cnt !== '0 || stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial: got id=%h exe=%h mem=%h wb=%h halt=%b cnt=%0d tmo=%b, want all NOP, 0", IR_ID, IR_EXE, IR_MEM, IR_WB, halted, stall_cnt, stall_timeout);
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(32'h1111_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h2222_0000, 1'b0, 1'b1, 1'b0);
        drive(32'h3333_0000, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL reset_prerun: got %h want %h", a, e); end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({IR_ID, IR_EXE, IR_MEM, IR_WB} !== {4{NOP_W}} || halted !== 1'b0 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_midrun: got id=%h exe=%h mem=%h wb=%h halt=%b cnt=%0d, want all NOP, 0", IR_ID, IR_EXE, IR_MEM, IR_WB, halted, stall_cnt);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        drive(32'h0401_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0802_0000, 1'b0, 1'b0, 1'b0);
        drive(NOP_W, 1'b0, 1'b0, 1'b0);
        drive(NOP_W, 1'b0, 1'b0, 1'b0);
        checks++;
        if (IR_WB !== 32'h0401_0000 || IR_MEM !== 32'h0802_0000) begin
            failures++;
            $display("FAIL stream_direct: got wb=%h mem=%h want wb=04010000 mem=08020000", IR_WB, IR_MEM);
        end
        drive(NOP_W, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL stream: got %h want %h", a, e); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(32'h0B0B_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0A0A_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0C0C_0000, 1'b0, 1'b1, 1'b0);
        checks++;
        if (IR_ID !== 32'h0A0A_0000 || IR_EXE !== NOP_W || IR_MEM !== 32'h0B0B_0000 || stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL stall_direct: got id=%h exe=%h mem=%h cnt=%0d want 0a0a0000 00000000 0b0b0000 1", IR_ID, IR_EXE, IR_MEM, stall_cnt);
        end
        drive(32'h0C0C_0000, 1'b1, 1'b0, 1'b0);
        drive(32'h0D0D_0000, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL stall: got %h want %h", a, e); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(32'h1C00_0001, 1'b0, 1'b0, 1'b0);
        drive(32'h0505_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0606_0000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (IR_ID !== NOP_W || IR_EXE !== NOP_W || IR_MEM !== 32'h1C00_0001 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL flush_direct: got id=%h exe=%h mem=%h cnt=%0d want 0 0 1c000001 0", IR_ID, IR_EXE, IR_MEM, stall_cnt);
        end
        drive(32'h0707_0000, 1'b0, 1'b1, 1'b1);
        drive(32'h0808_0000, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL flush: got %h want %h", a, e); end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 3; i++) drive(32'h0400_0000, 1'b0, 1'b1, 1'b0);
        checks++;
        if (stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_below: got tmo=%b want 0", stall_timeout);
        end
        drive(32'h0400_0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stall_timeout !== 1'b1 || stall_cnt !== 4'd4) begin
            failures++;
            $display("FAIL watchdog_trip: got tmo=%b cnt=%0d want 1 4", stall_timeout, stall_cnt);
        end
        drive(32'h0400_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0400_0000, 1'b1, 1'b1, 1'b1);
        checks++;
        if (stall_timeout !== 1'b1 || stall_cnt !== 4'd4) begin
            failures++;
            $display("FAIL watchdog_sticky: got tmo=%b cnt=%0d want 1 4", stall_timeout, stall_cnt);
        end
        // stall runs broken by stall+flush never trip a fresh watchdog
        do_reset();
        for (int i = 0; i < 9; i++) drive(32'h0400_0000, 1'b0, 1'b1, (i % 3) == 2);
        checks++;
        if (stall_timeout !== 1'b0 || stall_cnt !== 4'd6) begin
            failures++;
            $display("FAIL watchdog_broken: got tmo=%b cnt=%0d want 0 6", stall_timeout, stall_cnt);
        end
        do_reset();
        for (int i = 0; i < 18; i++) drive(32'h0400_0000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL cnt_saturate: got cnt=%0d want 15", stall_cnt);
        end
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL watchdog: got %h want %h", a, e); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(HALT_W, 1'b0, 1'b0, 1'b0);
        drive(32'h0101_0000, 1'b0, 1'b0, 1'b0);
        drive(32'h0202_0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_early: got halted=%b want 0", halted);
        end
        drive(32'h0303_0000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (halted !== 1'b1 || IR_WB !== HALT_W) begin
            failures++;
            $display("FAIL halt_set: got halted=%b wb=%h want 1 fc000000", halted, IR_WB);
        end
        drive(32'h0909_0000, 1'b0, 1'b1, 1'b0);
        drive(32'h0A0A_0000, 1'b0, 1'b0, 1'b1);
        drive(32'h0B0B_0000, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (pc_en !== 1'b0 || IR_WB !== HALT_W || IR_ID !== 32'h0303_0000 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL halt_frozen: got pc_en=%b wb=%h id=%h cnt=%0d want 0 fc000000 03030000 0", pc_en, IR_WB, IR_ID, stall_cnt);
        end
        // HALT killed in ID by a flush must not retire
        do_reset();
        drive(HALT_W, 1'b0, 1'b0, 1'b0);
        drive(32'h0404_0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(NOP_W, 1'b0, 1'b0, 1'b0);
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_flushed: got halted=%b want 0", halted);
        end
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL halt: got %h want %h", a, e); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w[31:26] == 6'h3F) w[26] = 1'b0;
            drive(w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end
        drive(HALT_W, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive($urandom, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            snap_t e, a;
            e = exp_q.pop_front(); a = act_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL random: got %h want %h", a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_watchdog();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer of the hazard detector's IsStall_IF/IsStall_ID: owns the IR pipeline registers IR_ID, IR_EXE, IR_MEM and IR_WB, and the PC-advance enable.
- On stall: holds the front end and injects a NOP bubble into EXE.
- On branch-taken flush: kills the younger instructions.
- Latches HALT at WB and keeps stall statistics plus a stall watchdog.

Parameters:
- WIDTH, 32, instruction width (matches the shared `WIDTH).
- CNT_W, 16, width of the saturating stall-cycle counter.
- MAX_STALL, 4, consecutive-stall threshold that trips the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock domain, asynchronous, active-low.
- IR_IF  in  WIDTH  instruction fetched this cycle.
- IsStall_IF  in  1  from hazard detect: hold PC and IF.
- IsStall_ID  in  1  from hazard detect: hold IR_ID and bubble EXE.
- flush  in  1  branch/jump taken, resolved in EXE.
- IR_ID  out  WIDTH  decode-stage instruction register.
- IR_EXE  out  WIDTH  execute-stage instruction register.
- IR_MEM  out  WIDTH  memory-stage instruction register.
- IR_WB  out  WIDTH  writeback-stage instruction register.
- pc_en  out  1  PC/fetch advance enable (combinational).
- halted  out  1  sticky, HALT retired.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- NOP_W = {`NOP, 26'b0} from the instruction-set include; HALT is detected on opcode bits [31:26] == `HALT.
- Reset (async, rst_n low), effective immediately regardless of operation in progress:
  - IR_ID, IR_EXE, IR_MEM and IR_WB = NOP_W.
  - halted = 0, stall_cnt = 0, stall_timeout = 0, internal consecutive counter = 0.
- stall = IsStall_IF | IsStall_ID. The stall input is sampled each rising edge, and the stall is single-cycle per assertion.
- Priority per rising edge: halted > flush > stall > normal.
- Normal:
  - IR_ID <= IR_IF, IR_EXE <= IR_ID, IR_MEM <= IR_EXE, IR_WB <= IR_MEM.
  - pc_en = 1.
- Stall (flush = 0):
  - IR_ID holds, IR_EXE <= NOP_W.
  - IR_MEM <= IR_EXE, IR_WB <= IR_MEM.
  - pc_en = 0.
- Flush (flush = 1, stall ignored):
  - IR_ID <= NOP_W, IR_EXE <= NOP_W.
  - IR_MEM <= IR_EXE (the branch itself retires), IR_WB <= IR_MEM.
  - pc_en = 1, so the target is fetched.
- Halted:
  - All four IRs hold.
  - pc_en = 0.
  - stall_cnt and the watchdog are frozen.
  - Only rst_n clears this state.
- halted is set on the edge where IR_MEM holds HALT (halted = 1 in the same cycle IR_WB shows HALT).
  - HALT in an earlier stage that gets flushed never sets halted.
- pc_en = ~halted & (flush | ~stall). This is purely combinational from the current inputs and state.
- stall_cnt increments by 1 on each edge with stall & ~flush & ~halted, and saturates at 2^CNT_W-1 (no wrap).
- Consecutive counter:
  - Increments on a counted stall edge and clears on any non-stall edge.
  - It saturates at MAX_STALL.
  - stall_timeout sets when the counter reaches MAX_STALL and stays set until reset.
  - A simultaneous stall and flush counts as a non-stall edge.
- A two-state FSM is sufficient: RUN and HALT.
  - RUN -> HALT on the IR_MEM==HALT edge.
  - HALT -> RUN only on reset.
- No X propagation: every register has an explicit reset value.

Decomposition:
- Shared include (existing Parameters.v / InstructionSet.v):
  - `WIDTH, `NOP, `HALT, and the NOP_W constant (add as `NOP_WORD).
  - Opcode field slice macros.
- One natural sub-module: stall_watchdog. It holds the saturating total counter, the consecutive counter and the sticky timeout, and has inputs clk, rst_n, count_en and clear.
- The IR register chain and FSM stay in the top module.

Test Plan:
- Reset mid-run: drive rst_n low asynchronously between edges -> all IRs = NOP_W immediately; halted = 0; stall_cnt = 0.
- Stream 32'h0401_0000, 32'h0802_0000 with no stall -> each word appears in IR_ID, IR_EXE, IR_MEM and IR_WB on successive edges; pc_en = 1 throughout.
- IsStall_ID = 1 for one edge with IR_ID = A, IR_EXE = B:
  - After the edge, IR_ID = A, IR_EXE = NOP_W, IR_MEM = B.
  - pc_en = 0 during the stall; stall_cnt = 1.
- flush and IsStall_IF both 1 with IR_EXE = BR:
  - After the edge, IR_ID = IR_EXE = NOP_W and IR_MEM = BR.
  - stall_cnt unchanged; pc_en = 1.
- Stall held for 4 edges (MAX_STALL = 4) -> stall_timeout = 1 after the 4th edge, stays 1 after the stall drops; stall_cnt = 4.
- HALT fed at IR_IF:
  - halted = 1 four edges later with IR_WB = HALT; all IRs then frozen; pc_en = 0.
  - A HALT flushed from ID never sets halted.
